// File: rtl/hand_pkg.sv
// Shared definitions for the sequential hand scorer.
// Holds the default build parameters, the derived-width helpers and the hand
// index constants. It also holds the per-hand occupancy state type.
package hand_pkg;

    localparam int NUM_HANDS_DEF   = 2;
    localparam int MAX_CARDS_DEF   = 3;
    localparam int MODULUS_DEF     = 10;
    localparam int FACE_LIMIT_DEF  = 9;
    localparam int NATURAL_MIN_DEF = 8;
    localparam int CARD_W_DEF      = 4;

    localparam int PLAYER = 0;
    localparam int DEALER = 1;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } hand_state_e;

    function automatic int score_w(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

    function automatic int cnt_w(input int max_cards);
        return (max_cards > 0) ? $clog2(max_cards + 1) : 1;
    endfunction

    function automatic int hand_w(input int num_hands);
        return (num_hands > 1) ? $clog2(num_hands) : 1;
    endfunction

endpackage

// File: rtl/hand_lane.sv
// One hand of the scorer: face-card mapping, modular running score, card
// count, full and latched natural flag.
// Ports:
//   slow_clock  clock
//   resetb      synchronous active-low reset
//   clear       synchronous clear of this hand
//   accept      a card is taken into this hand at this edge
//   card_value  raw card value
//   score       registered running score mod MODULUS
//   count       registered number of cards held
//   full        high when count == MAX_CARDS
//   natural     latched natural flag
//
// state      | meaning
// -----------+--------------------------------------
// ST_EMPTY   | no cards held (after reset or clear)
// ST_PARTIAL | 1 .. MAX_CARDS-1 cards held
// ST_FULL    | MAX_CARDS cards held, further cards refused
module hand_lane
    import hand_pkg::*;
#(
    parameter int MAX_CARDS   = MAX_CARDS_DEF,
    parameter int MODULUS     = MODULUS_DEF,
    parameter int FACE_LIMIT  = FACE_LIMIT_DEF,
    parameter int NATURAL_MIN = NATURAL_MIN_DEF,
    parameter int CARD_W      = CARD_W_DEF,
    parameter int SCORE_W     = score_w(MODULUS),
    parameter int CNT_W       = cnt_w(MAX_CARDS)
) (
    input  logic               slow_clock,
    input  logic               resetb,
    input  logic               clear,
    input  logic               accept,
    input  logic [CARD_W-1:0]  card_value,
    output logic [SCORE_W-1:0] score,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               natural
);

    localparam logic [CARD_W-1:0]  FACE_C = CARD_W'(FACE_LIMIT);
    localparam logic [SCORE_W:0]   MOD_C  = (SCORE_W + 1)'(MODULUS);
    localparam logic [SCORE_W-1:0] NAT_C  = SCORE_W'(NATURAL_MIN);
    localparam logic [CNT_W-1:0]   MAX_C  = CNT_W'(MAX_CARDS);
    localparam logic [CNT_W-1:0]   ONE_C  = CNT_W'(1);

    hand_state_e        state;
    logic [SCORE_W-1:0] card_pts;
    logic [SCORE_W:0]   sum;
    logic [SCORE_W-1:0] score_next;
    logic [CNT_W-1:0]   count_next;

    // Mapped points never exceed FACE_LIMIT < MODULUS, so one conditional
    // subtract at SCORE_W+1 bits is enough to stay in range.
    always_comb begin
        card_pts   = (card_value > FACE_C) ? '0 : SCORE_W'(card_value);
        sum        = {1'b0, score} + {1'b0, card_pts};
        if (sum >= MOD_C) begin
            sum = sum - MOD_C;
        end
        score_next = sum[SCORE_W-1:0];
        count_next = count + ONE_C;
    end

    always_ff @(posedge slow_clock) begin
        if (!resetb || clear) begin
            state   <= ST_EMPTY;
            score   <= '0;
            count   <= '0;
            natural <= 1'b0;
        end else if (accept) begin
            score <= score_next;
            count <= count_next;
            state <= (count_next == MAX_C) ? ST_FULL : ST_PARTIAL;
            // Natural is judged only on the second card and then held.
            if (count == ONE_C && score_next >= NAT_C) begin
                natural <= 1'b1;
            end
        end
    end

    assign full = (state == ST_FULL);

endmodule

// File: rtl/hand_scorer.sv
// Sequential multi-hand baccarat scorer. Cards arrive one per cycle over a
// valid/ready handshake and are routed to the hand named by card_hand.
// Ports:
//   slow_clock  clock, all state on its rising edge
//   resetb      synchronous active-low reset
//   clear       synchronous clear of every hand, wins over a card
//   card_valid  a card is presented
//   card_hand   destination hand index
//   card_value  raw card value
//   card_ready  combinational: index in range and that hand not full
//   score       per-hand running score
//   count       per-hand card count
//   full        per-hand full flag
//   natural     per-hand latched natural flag
//   overflow    one-cycle pulse after a presented card is refused
module hand_scorer
    import hand_pkg::*;
#(
    parameter  int NUM_HANDS   = NUM_HANDS_DEF,
    parameter  int MAX_CARDS   = MAX_CARDS_DEF,
    parameter  int MODULUS     = MODULUS_DEF,
    parameter  int FACE_LIMIT  = FACE_LIMIT_DEF,
    parameter  int NATURAL_MIN = NATURAL_MIN_DEF,
    parameter  int CARD_W      = CARD_W_DEF,
    localparam int SCORE_W     = score_w(MODULUS),
    localparam int CNT_W       = cnt_w(MAX_CARDS),
    localparam int HAND_W      = hand_w(NUM_HANDS)
) (
    input  logic                              slow_clock,
    input  logic                              resetb,
    input  logic                              clear,
    input  logic                              card_valid,
    input  logic [HAND_W-1:0]                 card_hand,
    input  logic [CARD_W-1:0]                 card_value,
    output logic                              card_ready,
    output logic [NUM_HANDS-1:0][SCORE_W-1:0] score,
    output logic [NUM_HANDS-1:0][CNT_W-1:0]   count,
    output logic [NUM_HANDS-1:0]              full,
    output logic [NUM_HANDS-1:0]              natural,
    output logic                              overflow
);

    logic [NUM_HANDS-1:0] hand_sel;
    logic [NUM_HANDS-1:0] accept;
    logic                 take;

    // An index that matches no hand leaves card_ready low, which turns the
    // card into a reject.
    always_comb begin
        hand_sel   = '0;
        card_ready = 1'b0;
        for (int i = 0; i < NUM_HANDS; i++) begin
            hand_sel[i] = (card_hand == HAND_W'(i));
            if (hand_sel[i]) begin
                card_ready = ~full[i];
            end
        end
        take   = card_valid & card_ready & ~clear & resetb;
        accept = hand_sel & {NUM_HANDS{take}};
    end

    always_ff @(posedge slow_clock) begin
        if (!resetb || clear) begin
            overflow <= 1'b0;
        end else begin
            overflow <= card_valid & ~card_ready;
        end
    end

    for (genvar g = 0; g < NUM_HANDS; g++) begin : g_lane
        hand_lane #(
            .MAX_CARDS   (MAX_CARDS),
            .MODULUS     (MODULUS),
            .FACE_LIMIT  (FACE_LIMIT),
            .NATURAL_MIN (NATURAL_MIN),
            .CARD_W      (CARD_W),
            .SCORE_W     (SCORE_W),
            .CNT_W       (CNT_W)
        ) u_lane (
            .slow_clock (slow_clock),
            .resetb     (resetb),
            .clear      (clear),
            .accept     (accept[g]),
            .card_value (card_value),
            .score      (score[g]),
            .count      (count[g]),
            .full       (full[g]),
            .natural    (natural[g])
        );
    end

endmodule

// File: tb/tb_hand_scorer.sv
// Directed bench for hand_scorer: a default two-hand build and a three-hand,
// four-card build share the clock and reset. Each stimulus cycle pushes its
// hand-computed expected outputs; a monitor pops and compares on the falling
// edge that follows.
module tb_hand_scorer;

    logic slow_clock = 1'b0;
    logic resetb     = 1'b0;
    always #5 slow_clock = ~slow_clock;

    // default build: 2 hands, 3 cards
    logic            clear_a = 1'b0, card_valid_a = 1'b0;
    logic            card_hand_a = 1'b0;
    logic [3:0]      card_value_a = '0;
    logic            card_ready_a;
    logic [1:0][3:0] score_a;
    logic [1:0][1:0] count_a;
    logic [1:0]      full_a, natural_a;
    logic            overflow_a;

    // wide build: 3 hands, 4 cards
    logic            clear_b = 1'b0, card_valid_b = 1'b0;
    logic [1:0]      card_hand_b = '0;
    logic [3:0]      card_value_b = '0;
    logic            card_ready_b;
    logic [2:0][3:0] score_b;
    logic [2:0][2:0] count_b;
    logic [2:0]      full_b, natural_b;
    logic            overflow_b;

    hand_scorer u_dut_a (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .clear      (clear_a),
        .card_valid (card_valid_a),
        .card_hand  (card_hand_a),
        .card_value (card_value_a),
        .card_ready (card_ready_a),
        .score      (score_a),
        .count      (count_a),
        .full       (full_a),
        .natural    (natural_a),
        .overflow   (overflow_a)
    );

    hand_scorer #(.NUM_HANDS(3), .MAX_CARDS(4), .MODULUS(10)) u_dut_b (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .clear      (clear_b),
        .card_valid (card_valid_b),
        .card_hand  (card_hand_b),
        .card_value (card_value_b),
        .card_ready (card_ready_b),
        .score      (score_b),
        .count      (count_b),
        .full       (full_b),
        .natural    (natural_b),
        .overflow   (overflow_b)
    );

    typedef struct {
        int         id;
        int         dut;
        logic [11:0] score;
        logic [8:0]  count;
        logic [2:0]  full;
        logic [2:0]  nat;
        logic        ovf;
        logic        rdy;
    } exp_t;

    exp_t q[$];
    int   tests    = 0;
    int   failures = 0;
    int   step_no  = 1;

    logic [11:0] act_score;
    logic [8:0]  act_count;
    logic [2:0]  act_full, act_nat;
    logic        act_ovf, act_rdy;
    exp_t        m;

    always @(negedge slow_clock) begin
        if (q.size() > 0) begin
            m = q.pop_front();
            if (m.dut == 0) begin
                act_score = {4'b0, score_a};
                act_count = {3'b0, 1'b0, count_a[1], 1'b0, count_a[0]};
                act_full  = {1'b0, full_a};
                act_nat   = {1'b0, natural_a};
                act_ovf   = overflow_a;
                act_rdy   = card_ready_a;
            end else begin
                act_score = score_b;
                act_count = count_b;
                act_full  = full_b;
                act_nat   = natural_b;
                act_ovf   = overflow_b;
                act_rdy   = card_ready_b;
            end
            tests++;
            if ({act_score, act_count, act_full, act_nat, act_ovf, act_rdy} !==
                {m.score, m.count, m.full, m.nat, m.ovf, m.rdy}) begin
                failures++;
                $display("FAIL step%0d dut%0d: got score=%h count=%h full=%b nat=%b ovf=%b rdy=%b, want score=%h count=%h full=%b nat=%b ovf=%b rdy=%b",
                         m.id, m.dut, act_score, act_count, act_full, act_nat, act_ovf, act_rdy,
                         m.score, m.count, m.full, m.nat, m.ovf, m.rdy);
            end
        end
    end

    // One clock of stimulus; the expected values describe the outputs after
    // that edge, with card_ready judged for the same card_hand and no card.
    task automatic step(input int dut, input bit v, input int h, input int val,
                        input bit clr, input bit rst,
                        input int s0, input int s1, input int s2,
                        input int c0, input int c1, input int c2,
                        input logic [2:0] f, input logic [2:0] n,
                        input bit ov, input bit rdy);
        exp_t e;
        resetb = ~rst;
        if (dut == 0) begin
            card_valid_a = v;
            card_hand_a  = 1'(h);
            card_value_a = 4'(val);
            clear_a      = clr;
        end else begin
            card_valid_b = v;
            card_hand_b  = 2'(h);
            card_value_b = 4'(val);
            clear_b      = clr;
        end
        @(posedge slow_clock);
        #1;
        e.id    = step_no;
        e.dut   = dut;
        e.score = {4'(s2), 4'(s1), 4'(s0)};
        e.count = {3'(c2), 3'(c1), 3'(c0)};
        e.full  = f;
        e.nat   = n;
        e.ovf   = ov;
        e.rdy   = rdy;
        q.push_back(e);
        step_no++;
        card_valid_a = 1'b0;
        card_valid_b = 1'b0;
        clear_a      = 1'b0;
        clear_b      = 1'b0;
        resetb       = 1'b1;
        @(negedge slow_clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //    dut v h val clr rst  s0 s1 s2 c0 c1 c2 full    nat     ov rdy
        step(0, 0, 0, 0,  0, 1,   0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 1);
        // three face cards fill the player hand at score 0
        step(0, 1, 0, 10, 0, 0,   0, 0, 0, 1, 0, 0, 3'b000, 3'b000, 0, 1);
        step(0, 1, 0, 10, 0, 0,   0, 0, 0, 2, 0, 0, 3'b000, 3'b000, 0, 1);
        step(0, 1, 0, 10, 0, 0,   0, 0, 0, 3, 0, 0, 3'b001, 3'b000, 0, 0);
        step(0, 0, 0, 0,  1, 0,   0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 1);
        // dealer 9, 8, 12: 17 wraps to 7, no natural
        step(0, 1, 1, 9,  0, 0,   0, 9, 0, 0, 1, 0, 3'b000, 3'b000, 0, 1);
        step(0, 1, 1, 8,  0, 0,   0, 7, 0, 0, 2, 0, 3'b000, 3'b000, 0, 1);
        step(0, 1, 1, 12, 0, 0,   0, 7, 0, 0, 3, 0, 3'b010, 3'b000, 0, 0);
        // clear with a card to a full hand: dropped, no overflow
        step(0, 1, 1, 5,  1, 0,   0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 1);
        // player 4, 5 natural 9, then 3 keeps natural
        step(0, 1, 0, 4,  0, 0,   4, 0, 0, 1, 0, 0, 3'b000, 3'b000, 0, 1);
        step(0, 1, 0, 5,  0, 0,   9, 0, 0, 2, 0, 0, 3'b000, 3'b001, 0, 1);
        step(0, 1, 0, 3,  0, 0,   2, 0, 0, 3, 0, 0, 3'b001, 3'b001, 0, 0);
        // dealer 8, 0: natural at exactly NATURAL_MIN, player untouched
        step(0, 1, 1, 8,  0, 0,   2, 8, 0, 3, 1, 0, 3'b001, 3'b001, 0, 1);
        step(0, 1, 1, 0,  0, 0,   2, 8, 0, 3, 2, 0, 3'b001, 3'b011, 0, 1);
        step(0, 0, 0, 0,  1, 0,   0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 1);
        // 2, 2, 6 wraps exactly to 0; a fourth card is refused for one cycle
        step(0, 1, 0, 2,  0, 0,   2, 0, 0, 1, 0, 0, 3'b000, 3'b000, 0, 1);
        step(0, 1, 0, 2,  0, 0,   4, 0, 0, 2, 0, 0, 3'b000, 3'b000, 0, 1);
        step(0, 1, 0, 6,  0, 0,   0, 0, 0, 3, 0, 0, 3'b001, 3'b000, 0, 0);
        step(0, 1, 0, 5,  0, 0,   0, 0, 0, 3, 0, 0, 3'b001, 3'b000, 1, 0);
        step(0, 0, 0, 0,  0, 0,   0, 0, 0, 3, 0, 0, 3'b001, 3'b000, 0, 0);
        step(0, 1, 0, 5,  1, 0,   0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 1);
        // reset mid-hand after 7, 8 (score 5), card during reset ignored
        step(0, 1, 0, 7,  0, 0,   7, 0, 0, 1, 0, 0, 3'b000, 3'b000, 0, 1);
        step(0, 1, 0, 8,  0, 0,   5, 0, 0, 2, 0, 0, 3'b000, 3'b000, 0, 1);
        step(0, 1, 0, 3,  0, 1,   0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 1);
        // first card after reset, natural 9, face value 15 scores 0
        step(0, 1, 0, 9,  0, 0,   9, 0, 0, 1, 0, 0, 3'b000, 3'b000, 0, 1);
        step(0, 1, 0, 0,  0, 0,   9, 0, 0, 2, 0, 0, 3'b000, 3'b001, 0, 1);
        step(0, 1, 0, 15, 0, 0,   9, 0, 0, 3, 0, 0, 3'b001, 3'b001, 0, 0);
        // three-hand, four-card build: 1, 11, 3, 9 to hand 2
        step(1, 1, 2, 1,  0, 0,   0, 0, 1, 0, 0, 1, 3'b000, 3'b000, 0, 1);
        step(1, 1, 2, 11, 0, 0,   0, 0, 1, 0, 0, 2, 3'b000, 3'b000, 0, 1);
        step(1, 1, 2, 3,  0, 0,   0, 0, 4, 0, 0, 3, 3'b000, 3'b000, 0, 1);
        step(1, 1, 2, 9,  0, 0,   0, 0, 3, 0, 0, 4, 3'b100, 3'b000, 0, 0);
        // index 3 is out of range
        step(1, 1, 3, 5,  0, 0,   0, 0, 3, 0, 0, 4, 3'b100, 3'b000, 1, 0);
        step(1, 0, 3, 0,  0, 0,   0, 0, 3, 0, 0, 4, 3'b100, 3'b000, 0, 0);
        step(1, 1, 0, 9,  0, 0,   9, 0, 3, 1, 0, 4, 3'b100, 3'b000, 0, 1);
        step(1, 1, 2, 1,  0, 0,   9, 0, 3, 1, 0, 4, 3'b100, 3'b000, 1, 0);

        repeat (2) @(negedge slow_clock);
        if (q.size() != 0) begin
            tests++;
            failures++;
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/hand_scorer.md
# hand_scorer

Sequential, parametrised successor to the combinational three-card baccarat scorer. It accepts cards one at a time over a valid/ready handshake and routes each card to one of NUM_HANDS hands. For each hand it keeps a registered running score mod MODULUS, a card count, a full flag and a latched natural flag. It sits between the card dealer and the game state machine, replacing per-hand combinational scoring.

## Interface
- NUM_HANDS, 2: number of independent hands; index 0 = player, 1 = dealer.
- MAX_CARDS, 3: maximum cards accepted per hand.
- MODULUS, 10: score modulus; must exceed FACE_LIMIT.
- FACE_LIMIT, 9: card values above this score as 0.
- NATURAL_MIN, 8: minimum two-card score that sets natural.
- CARD_W, 4: card value width.
- slow_clock  in  1  sole clock; all state updates on its rising edge.
- resetb  in  1  synchronous, active-low reset.
- clear  in  1  synchronous clear of all hands; takes priority over card input.
- card_valid  in  1  a card is presented this cycle.
- card_hand  in  HAND_W = max(1, $clog2(NUM_HANDS))  destination hand index.
- card_value  in  CARD_W  raw card value, 0..2^CARD_W−1.
- card_ready  out  1  combinational; 1 when card_hand is in range and that hand is not full.
- score  out  NUM_HANDS × SCORE_W (SCORE_W = $clog2(MODULUS))  registered running score per hand.
- count  out  NUM_HANDS × CNT_W (CNT_W = $clog2(MAX_CARDS+1))  registered cards accepted per hand.
- full  out  NUM_HANDS  registered; 1 when count == MAX_CARDS.
- natural  out  NUM_HANDS  registered; latched natural flag.
- overflow  out  1  registered one-cycle pulse when a presented card is rejected.

## Operation
- Accept condition: card_valid & card_ready & ~clear & resetb.
- Card mapping: v = (card_value > FACE_LIMIT) ? 0 : card_value, so v is in 0..FACE_LIMIT.
- Score update: s = score + v, computed at SCORE_W+1 bits; if s ≥ MODULUS then s −= MODULUS. No division is used.
- On accept, the selected hand's count increments. full asserts when count reaches MAX_CARDS.
- natural sets on the accept that brings count from 1 to 2, if the new score ≥ NATURAL_MIN. Once set, it holds until clear or reset; later cards do not drop it.
- Rejection: card_valid & ~card_ready & ~clear raises overflow on the next cycle. A reject covers a full hand or an out-of-range index. All hand state is unchanged.
- clear: zeroes score, count, full and natural for every hand, and overflow, at the next edge. A card presented in the same cycle is dropped silently, with no overflow pulse.
- Per-hand state follows count: EMPTY (0) → PARTIAL (1..MAX_CARDS−1) → FULL (MAX_CARDS) → EMPTY on clear.
- Hands are fully independent; only the hand addressed by card_hand changes on any edge.

## Timing
- Reset (resetb = 0 at an edge): every score, count, full, natural and overflow output is 0.
- Latency: an accepted card is visible on score, count, full and natural one edge after acceptance.
- Throughput: one card per cycle, including back-to-back cards to the same hand.
- card_ready is combinational from full and card_hand, so producers may sample it in the same cycle. It drops in the cycle after the card that fills the hand.
- Priority at an edge: resetb, then clear, then accept or reject.
- Reset asserted mid-hand discards partial scores. The first card after resetb rises is accepted normally.

## Structure
- Shared package hand_pkg holds the default parameters, the SCORE_W, CNT_W and HAND_W derivation functions, and the hand index constants PLAYER = 0 and DEALER = 1.
- Sub-module hand_lane implements one hand: mapping, mod add, count, full and natural registers. It is instantiated NUM_HANDS times in a generate loop.
- The top level holds only the index decode, card_ready mux and overflow register.

## Test plan
- Reset, then cards 10, 10, 10 to hand 0 → score[0] = 0, count[0] = 3, full[0] = 1, card_ready = 0 for hand 0; hand 1 stays all 0.
- Cards 9, 8, 12 to hand 1 on consecutive cycles → score[1] = 7 one cycle after the third card; natural[1] = 0, because the two-card score is 17 mod 10 = 7.
- Cards 4, 5 to hand 0 → score[0] = 9 and natural[0] = 1. A third card, 3, gives score 2 with natural still 1.
- Cards 2, 2, 6 to hand 0 → score[0] = 0 (exact wrap); a fourth card, 5 → overflow = 1 for exactly one cycle, score still 0, count still 3.
- clear with card_valid = 1 in the same cycle → all outputs 0 next cycle, no overflow. resetb = 0 after two cards of 7 and 8 (score 5) → score and count return to 0.
- Parametrised build with NUM_HANDS = 3, MAX_CARDS = 4, MODULUS = 10 → cards 1, 11, 3, 9 to hand 2 give score 3, count 4; a card to index 3 gives an overflow pulse.
